clk_div_prog: RTL

//  Multi-channel programmable clock-enable divider; parametrised successor to the fixed /2,/4,/8 divider.

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_chan.sv | 105 ++++++++++
 rtl/clk_div_prog.sv | 46 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the programmable clock-enable divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DIV_MIN   = 2;

  // Per-cycle channel action, resolved in priority order: en low > sync > run.
  typedef enum logic [1:0] {
    CH_HOLD,
    CH_SYNC,
    CH_RUN
  } ch_act_e;

  // Ratios 0 and 1 have no usable high/low split, so they behave as the minimum ratio.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < DIV_MIN) ? 32'(DIV_MIN) : v;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow ratio, registered level, tick and pending flag.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;
  ch_act_e          act;

  assign half    = ratio_q >> 1;
  assign wrap    = (cnt_q == ratio_q - CNT_W'(1));
  assign cnt_nxt = wrap ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    if (!en_i)       act = CH_HOLD;
    else if (sync_i) act = CH_SYNC;
    else             act = CH_RUN;
  end

  always_comb begin
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    shadow_d = shadow_q;
    div_d    = div_q;
    tick_d   = tick_q;
    pend_d   = pend_q;

    case (act)
      CH_HOLD: begin
        cnt_d   = '0;
        div_d   = 1'b0;
        tick_d  = 1'b0;
        ratio_d = shadow_q;
        pend_d  = 1'b0;
      end
      CH_SYNC: begin
        cnt_d   = '0;
        div_d   = 1'b1;
        tick_d  = 1'b1;
        ratio_d = shadow_q;
        pend_d  = 1'b0;
      end
      default: begin
        cnt_d  = cnt_nxt;
        div_d  = (cnt_nxt < half);
        tick_d = (cnt_nxt == '0);
        // Ratio only swaps at the period boundary so no runt phase is emitted.
        if (wrap) begin
          ratio_d = shadow_q;
          pend_d  = 1'b0;
        end
      end
    endcase

    // A write coinciding with a load is held for the following boundary.
    if (we_i) begin
      shadow_d = CNT_W'(clamp_div(32'(val_i)));
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      ratio_q  <= CNT_W'(DEF_DIV);
      shadow_q <= CNT_W'(DEF_DIV);
      div_q    <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign clk_div_o = div_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock-enable divider with shared ratio write port and phase sync.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = 2,
  localparam int unsigned SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [NCH-1:0]   clk_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  logic [NCH-1:0] we_ch;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

    // Out-of-range selects match no channel and are dropped.
    assign we_ch[i] = div_we && (div_sel == IDX);

    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en[i]),
      .sync_i   (sync),
      .we_i     (we_ch[i]),
      .val_i    (div_val),
      .clk_div_o(clk_div[i]),
      .tick_o   (tick[i]),
      .pend_o   (pend[i])
    );
  end

endmodule
